// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a shift counter that pulses frame_done on every WIDTH-th shift.
module universal_shift_register #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [1:0]               mode,
   input  logic                     sin_r,
   input  logic                     sin_l,
   input  logic [WIDTH-1:0]         pdata,
   output logic [WIDTH-1:0]         q,
   output logic                     sout_r,
   output logic                     sout_l,
   output logic [$clog2(WIDTH)-1:0] count,
   output logic                     frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      M_HOLD = 2'b00,
      M_SHR  = 2'b01,
      M_SHL  = 2'b10,
      M_LOAD = 2'b11
   } mode_t;

   mode_t op;
   logic  shifting;

   assign op       = mode_t'(mode);
   assign shifting = en && (op == M_SHR || op == M_SHL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RESET_VALUE;
      end else if (en) begin
         case (op)
            M_SHR:   q <= {sin_r, q[WIDTH-1:1]};
            M_SHL:   q <= {q[WIDTH-2:0], sin_l};
            M_LOAD:  q <= pdata;
            default: q <= q;
         endcase
      end
   end

   // Shifts in either direction share one frame counter; a load restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (en && op == M_LOAD) begin
            count <= '0;
         end else if (shifting) begin
            if (count == LAST) begin
               count      <= '0;
               frame_done <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: arithmetic reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_universal_shift_register;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       sin_r, sin_l;
   logic [7:0] pdata;
   logic [7:0] q;
   logic       sout_r, sout_l;
   logic [2:0] count;
   logic       frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
      .pdata(pdata), .q(q), .sout_r(sout_r), .sout_l(sout_l), .count(count),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a byte, shifts as a running total since
   // the last load/reset; count and frame completion follow from modulo.
   logic [7:0] m_q;
   int         m_n;
   logic       m_fd;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q  <= RV;
         m_n  <= 0;
         m_fd <= 1'b0;
      end else begin
         m_fd <= 1'b0;
         if (en) begin
            case (mode)
               2'b01: begin
                  m_q  <= (m_q >> 1) | (8'(sin_r) << (W - 1));
                  m_n  <= m_n + 1;
                  m_fd <= ((m_n + 1) % W) == 0;
               end
               2'b10: begin
                  m_q  <= (m_q << 1) | 8'(sin_l);
                  m_n  <= m_n + 1;
                  m_fd <= ((m_n + 1) % W) == 0;
               end
               2'b11: begin
                  m_q <= pdata;
                  m_n <= 0;
               end
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_q", 32'(q), 32'(m_q));
      chk("model_sout_r", 32'(sout_r), 32'(m_q[0]));
      chk("model_sout_l", 32'(sout_l), 32'(m_q[W-1]));
      chk("model_count", 32'(count), 32'(m_n % W));
      chk("model_fd", 32'(frame_done), 32'(m_fd));
   end

   task automatic step(input logic e, input logic [1:0] m, input logic sr,
                       input logic sl, input logic [7:0] pd);
      en = e; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2 rst = 1'b0;
      #1;
      chk("arst_q", 32'(q), 32'(RV));
      chk("arst_count", 32'(count), 0);
      chk("arst_fd", 32'(frame_done), 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] bits;
      rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pdata = 8'h00;
      @(negedge clk);
      chk("reset_q", 32'(q), 32'h A5);
      chk("reset_count", 32'(count), 0);
      rst = 1'b1;

      // Asynchronous reset between edges
      step(1, 2'b11, 0, 0, 8'h3C);
      chk("load_3c", 32'(q), 32'h3C);
      async_reset();

      // SISO right shift of 1,0,1,0,0,0,1,1
      step(1, 2'b11, 0, 0, 8'h00);
      bits = 8'b1100_0101;
      for (int i = 0; i < 8; i++) begin
         step(1, 2'b01, bits[i], 0, 8'h00);
         chk("rsh_fd", 32'(frame_done), 32'(i == 7));
      end
      chk("rsh_q", 32'(q), 32'hC5);
      chk("rsh_sout_r", 32'(sout_r), 1);
      step(1, 2'b00, 0, 0, 8'h00);
      chk("rsh_fd_drop", 32'(frame_done), 0);

      // Parallel load then left shift
      step(1, 2'b11, 0, 0, 8'h81);
      chk("pl_q", 32'(q), 32'h81);
      chk("pl_sout_l", 32'(sout_l), 1);
      step(1, 2'b10, 0, 0, 8'h00);
      chk("lsh1_q", 32'(q), 32'h02);
      chk("lsh1_sout_l", 32'(sout_l), 0);
      step(1, 2'b10, 0, 0, 8'h00);
      chk("lsh2_q", 32'(q), 32'h04);

      // Enable and hold mid-frame
      step(1, 2'b11, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(1, 2'b01, 1, 0, 8'h00);
      chk("hold_count3", 32'(count), 3);
      chk("hold_q", 32'(q), 32'hE0);
      for (int i = 0; i < 4; i++) begin
         step(0, 2'b01, 0, 0, 8'hFF);
         chk("en0_count", 32'(count), 3);
         chk("en0_q", 32'(q), 32'hE0);
         chk("en0_fd", 32'(frame_done), 0);
      end
      for (int i = 0; i < 2; i++) begin
         step(1, 2'b00, 0, 0, 8'hFF);
         chk("hold_count", 32'(count), 3);
         chk("hold_q2", 32'(q), 32'hE0);
      end
      for (int i = 0; i < 5; i++) begin
         step(1, 2'b10, 0, 1, 8'h00);
         chk("resume_fd", 32'(frame_done), 32'(i == 4));
      end

      // Mixed direction: 3 right then 5 left
      step(1, 2'b11, 0, 0, 8'h5A);
      for (int i = 0; i < 8; i++) begin
         step(1, (i < 3) ? 2'b01 : 2'b10, 1, 0, 8'h00);
         chk("mix_fd", 32'(frame_done), 32'(i == 7));
      end
      chk("mix_count", 32'(count), 0);

      // Load aborts a partial frame
      for (int i = 0; i < 4; i++) step(1, 2'b01, 0, 0, 8'h00);
      chk("abort_count4", 32'(count), 4);
      step(1, 2'b11, 0, 0, 8'h77);
      chk("abort_count0", 32'(count), 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 2'b10, 1, 1, 8'h00);
         chk("abort_fd", 32'(frame_done), 32'(i == 7));
      end

      // Reset mid-frame
      for (int i = 0; i < 6; i++) step(1, 2'b01, 1, 0, 8'h00);
      chk("rmid_count6", 32'(count), 6);
      async_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, 2'b01, 0, 0, 8'h00);
         chk("rmid_fd", 32'(frame_done), 32'(i == 7));
      end

      // Continuous shifting: pulse every 8 cycles
      for (int i = 0; i < 16; i++) begin
         step(1, 2'b10, i[0], 0, 8'h00);
         chk("cont_fd", 32'(frame_done), 32'(i == 7 || i == 15));
      end

      step(1, 2'b00, 0, 0, 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the serial-in/serial-out shift register. Provides hold, shift right, shift left and parallel load on a WIDTH-bit register. Has separate serial inputs and outputs per direction and a shift counter that flags each complete WIDTH-bit frame. Used as the general serial/parallel converter wherever a fixed SISO chain was used before.

Parameters:
WIDTH, 8, register width in bits; must be at least 2.
RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
en  input  1  clock enable; when 0, all state holds.
mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
sin_r  input  1  serial input for right shift; enters the MSB.
sin_l  input  1  serial input for left shift; enters the LSB.
pdata  input  WIDTH  parallel load data.
q  output  WIDTH  register contents.
sout_r  output  1  right-shift serial output; equals q[0] (combinational from q).
sout_l  output  1  left-shift serial output; equals q[WIDTH-1] (combinational from q).
count  output  $clog2(WIDTH)  number of shifts since the last load, reset or frame wrap.
frame_done  output  1  one-cycle registered pulse on completion of WIDTH shifts.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - q=RESET_VALUE, count=0, frame_done=0.
  - Takes effect mid-operation, discarding any partial frame.
  - After rst deasserts, the first active edge operates normally.
- All other updates occur on the rising edge of clk only when en=1.
- en=0:
  - q and count hold.
  - frame_done=0 on that edge.
- mode 00 (hold):
  - q and count hold.
  - frame_done=0.
- mode 01 (shift right): q <= {sin_r, q[WIDTH-1:1]}.
- mode 10 (shift left): q <= {q[WIDTH-2:0], sin_l}.
- mode 11 (parallel load):
  - q <= pdata.
  - count <= 0.
  - frame_done=0.
- Latency:
  - A bit on sin_r appears at sout_r after exactly WIDTH right-shift edges.
  - The same holds for sin_l to sout_l with left-shift edges.
  - sout_r and sout_l follow q with no extra register stage.
- Counter, on every enabled shift (mode 01 or 10):
  - If count == WIDTH-1: count <= 0 and frame_done <= 1 on that edge.
  - Otherwise: count <= count+1 and frame_done <= 0.
- Direction changes (01 to 10 or back) mid-frame do not reset count; shifts in either direction accumulate.
- frame_done is high for exactly one cycle per completed frame.
- With continuous shifting, frame_done pulses every WIDTH cycles.
- Inputs are sampled only at the active edge; there is no combinational path from inputs to q.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, rst=0 asserted between clock edges -> q=8'hA5, count=0, frame_done=0 immediately, without waiting for clk.
- SISO right shift: load 8'h00, mode=01, drive sin_r bitstream 1,0,1,0,0,0,1,1 -> q=8'hC5 after 8 edges; frame_done high only on the 8th edge; sout_r shows the first bit (1) after 8 edges.
- Left shift and parallel load: pdata=8'h81, mode=11 -> q=8'h81; then mode=10 with sin_l=0 -> q=8'h02, then 8'h04; sout_l=1 before the first shift and 0 after.
- Enable and hold: mid-frame with count=3, set en=0 for 4 cycles, then mode=00 for 2 cycles -> q and count unchanged, frame_done=0; resume shifting -> frame_done fires after 5 more shifts.
- Mixed direction and load abort: 3 right shifts then 5 left shifts -> frame_done pulses on the 8th shift. Separately, 4 shifts then a parallel load -> count=0, and no frame_done until 8 further shifts.
- Reset mid-frame: rst=0 at count=6 -> count=0, q=RESET_VALUE; after release, 8 shifts are needed for frame_done.
